aux_cnt_cmp: RTL and testbench

AUX_CNT_CMP -- requirements
Module: aux_cnt_cmp

---
 rtl/aux_cnt_pkg.sv | 18 +
 rtl/aux_cnt_cell.sv | 46 ++++
 rtl/aux_cnt_cmp.sv | 173 +++++++++++++++++
 tb/tb_aux_cnt_cmp.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_cnt_pkg.sv
// ---------------------------------------------------------------------------
// aux_cnt_pkg
// Shared definitions for the auxiliary two-level counter/comparator block.
// Holds the traversal FSM state type and the default WIDTH/OFFSET values
// used by aux_cnt_cmp and its counter cell.
// ---------------------------------------------------------------------------
package aux_cnt_pkg;

    localparam int          DEFAULT_WIDTH  = 6;
    localparam int unsigned DEFAULT_OFFSET = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/aux_cnt_cell.sv
// ---------------------------------------------------------------------------
// aux_cnt_cell
// One WIDTH-bit counter with synchronous clear, increment and a compare
// against an externally supplied target.
//
// Ports
//   clk    : clock, rising edge
//   rstn   : asynchronous active-low reset, clears the count
//   clr_i  : synchronous clear (wins over inc_i)
//   inc_i  : increment by one, wrapping at 2^WIDTH
//   target : value compared against the current count
//   count  : registered count value
//   match  : count == target
// ---------------------------------------------------------------------------
module aux_cnt_cell
    import aux_cnt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic             match
);

    logic [WIDTH-1:0] count_q;

    // Count register: clear takes priority so a wrap (clear) and a stray
    // increment in the same cycle always land on zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
    assign match = (count_q == target);

endmodule

// File: rtl/aux_cnt_cmp.sv
// ---------------------------------------------------------------------------
// aux_cnt_cmp
// Two-level (row/column) traversal counter. A start in IDLE latches size_i;
// the terminal value is (size + OFFSET) mod 2^WIDTH. Each step advances the
// column; when the column is at the terminal value it wraps to zero and the
// row advances. The step that finds both at the terminal value ends the
// traversal, so a traversal takes (target+1)^2 steps.
//
// Parameters
//   WIDTH  : counter / size width
//   OFFSET : unsigned value added to the latched size
//
// Ports
//   clk       : clock, rising edge
//   rstn      : asynchronous active-low reset
//   start_i   : begin a traversal (honoured only in IDLE)
//   size_i    : traversal size, sampled when start_i is honoured
//   step_i    : advance one position while in RUN
//   ack_i     : acknowledge done_o (only meaningful in DONE)
//   abort_i   : (AUX_CNT_CMP_ABORT_EN only) return to IDLE from RUN/DONE
//   col_o     : inner (column) count
//   row_o     : outer (row) count
//   busy_o    : high while in RUN
//   row_end_o : one-cycle pulse on every column wrap, including the last
//   done_o    : high in DONE until acknowledged
//
// Build option
//   AUX_CNT_CMP_ABORT_EN : adds abort_i; abort beats step_i and ack_i.
// ---------------------------------------------------------------------------
module aux_cnt_cmp
    import aux_cnt_pkg::*;
#(
    parameter int          WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned OFFSET = DEFAULT_OFFSET
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic [WIDTH-1:0] size_i,
    input  logic             step_i,
    input  logic             ack_i,
`ifdef AUX_CNT_CMP_ABORT_EN
    input  logic             abort_i,
`endif
    output logic [WIDTH-1:0] col_o,
    output logic [WIDTH-1:0] row_o,
    output logic             busy_o,
    output logic             row_end_o,
    output logic             done_o
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] size_q;
    logic [WIDTH-1:0] target;
    logic             size_load;
    logic             col_clr, col_inc, row_clr, row_inc;
    logic             col_match, row_match;
    logic             row_end_d;
    logic             row_end_q, busy_q, done_q;

    // Terminal value wraps modulo 2^WIDTH; no saturation is intended.
    assign target = size_q + WIDTH'(OFFSET);

    aux_cnt_cell #(.WIDTH(WIDTH)) u_col (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (col_clr),
        .inc_i  (col_inc),
        .target (target),
        .count  (col_o),
        .match  (col_match)
    );

    aux_cnt_cell #(.WIDTH(WIDTH)) u_row (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (row_clr),
        .inc_i  (row_inc),
        .target (target),
        .count  (row_o),
        .match  (row_match)
    );

    // Next-state and counter control. Counters are cleared on every entry
    // to IDLE (ack or abort) and again on start, so a traversal always
    // begins from 0/0. On the final step both counters hold so the last
    // position stays visible while done_o is high.
    always_comb begin
        state_d   = state_q;
        size_load = 1'b0;
        col_clr   = 1'b0;
        col_inc   = 1'b0;
        row_clr   = 1'b0;
        row_inc   = 1'b0;
        row_end_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    size_load = 1'b1;
                    col_clr   = 1'b1;
                    row_clr   = 1'b1;
                end
            end
            RUN: begin
`ifdef AUX_CNT_CMP_ABORT_EN
                if (abort_i) begin
                    state_d = IDLE;
                    col_clr = 1'b1;
                    row_clr = 1'b1;
                end else
`endif
                if (step_i) begin
                    if (!col_match) begin
                        col_inc = 1'b1;
                    end else if (!row_match) begin
                        col_clr   = 1'b1;
                        row_inc   = 1'b1;
                        row_end_d = 1'b1;
                    end else begin
                        row_end_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
`ifdef AUX_CNT_CMP_ABORT_EN
                if (abort_i) begin
                    state_d = IDLE;
                    col_clr = 1'b1;
                    row_clr = 1'b1;
                end else
`endif
                if (ack_i) begin
                    state_d = IDLE;
                    col_clr = 1'b1;
                    row_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                col_clr = 1'b1;
                row_clr = 1'b1;
            end
        endcase
    end

    // State, latched size and the status flags. busy/done are registered
    // from the next state so they line up with the counter values that
    // the same edge produces.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            size_q    <= '0;
            row_end_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (size_load) begin
                size_q <= size_i;
            end
            row_end_q <= row_end_d;
            busy_q    <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign busy_o    = busy_q;
    assign row_end_o = row_end_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_aux_cnt_cmp.sv
// ---------------------------------------------------------------------------
// tb_aux_cnt_cmp
// Self-checking bench for aux_cnt_cmp. The main instance uses the defaults
// (WIDTH=6, OFFSET=0); a second instance with OFFSET=1 covers target wrap.
// Expected outputs come from a traversal model that tracks only the number
// of steps taken and derives column/row by division.
// ---------------------------------------------------------------------------
module tb_aux_cnt_cmp;

    localparam int W      = 6;
    localparam int MODV   = 64;
    localparam int OFF_A  = 0;

    typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start_i, step_i, ack_i;
    logic [W-1:0] size_i;
    logic [W-1:0] col_o, row_o;
    logic         busy_o, row_end_o, done_o;

    logic         start_b, step_b, ack_b;
    logic [W-1:0] size_b;
    logic [W-1:0] col_b, row_b;
    logic         busy_b, row_end_b, done_b;

`ifdef AUX_CNT_CMP_ABORT_EN
    logic         abort_i;
    logic         abort_b;
`endif

    logic [14:0]  obs;
    assign obs = {col_o, row_o, busy_o, row_end_o, done_o};

    int n_checks = 0;
    int n_pass   = 0;

    mstate_t m_st   = M_IDLE;
    int      m_k    = 0;
    int      m_size = 0;
    bit      m_re   = 1'b0;

    always #5 clk = ~clk;

    aux_cnt_cmp #(.WIDTH(W), .OFFSET(OFF_A)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .size_i    (size_i),
        .step_i    (step_i),
        .ack_i     (ack_i),
`ifdef AUX_CNT_CMP_ABORT_EN
        .abort_i   (abort_i),
`endif
        .col_o     (col_o),
        .row_o     (row_o),
        .busy_o    (busy_o),
        .row_end_o (row_end_o),
        .done_o    (done_o)
    );

    aux_cnt_cmp #(.WIDTH(W), .OFFSET(1)) dut_off (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_b),
        .size_i    (size_b),
        .step_i    (step_b),
        .ack_i     (ack_b),
`ifdef AUX_CNT_CMP_ABORT_EN
        .abort_i   (abort_b),
`endif
        .col_o     (col_b),
        .row_o     (row_b),
        .busy_o    (busy_b),
        .row_end_o (row_end_b),
        .done_o    (done_b)
    );

    // Model: a traversal is (t+1)^2 steps in row-major order, so after k
    // steps the position is k mod (t+1), k div (t+1), except that the
    // final step leaves the position at t,t.
    function automatic int m_target();
        return (m_size + OFF_A) % MODV;
    endfunction

    function automatic logic [14:0] exp_vec();
        int t, n, c, r;
        t = m_target();
        n = (t + 1) * (t + 1);
        if (m_st == M_IDLE) begin
            c = 0;
            r = 0;
        end else if (m_k == n) begin
            c = t;
            r = t;
        end else begin
            c = m_k % (t + 1);
            r = m_k / (t + 1);
        end
        return {W'(c), W'(r), (m_st == M_RUN), m_re, (m_st == M_DONE)};
    endfunction

    task automatic model_edge(input bit s, input int sz, input bit st, input bit a, input bit ab);
        int t;
        m_re = 1'b0;
        case (m_st)
            M_IDLE: if (s) begin
                m_st   = M_RUN;
                m_size = sz;
                m_k    = 0;
            end
            M_RUN: if (ab) begin
                m_st = M_IDLE;
            end else if (st) begin
                t   = m_target();
                m_k = m_k + 1;
                if (m_k % (t + 1) == 0) m_re = 1'b1;
                if (m_k == (t + 1) * (t + 1)) m_st = M_DONE;
            end
            M_DONE: if (ab || a) m_st = M_IDLE;
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic model_reset();
        m_st   = M_IDLE;
        m_k    = 0;
        m_size = 0;
        m_re   = 1'b0;
    endtask

    // Drive one cycle on the main instance; inputs change 1 time unit after
    // the edge and outputs are then read 1 time unit after the next edge.
    task automatic drive_cycle(input bit s, input int sz, input bit st, input bit a, input bit ab);
        start_i = s;
        size_i  = W'(sz);
        step_i  = st;
        ack_i   = a;
`ifdef AUX_CNT_CMP_ABORT_EN
        abort_i = ab;
`endif
        @(posedge clk);
        model_edge(s, sz, st, a, ab);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (obs !== 15'd0) $display("[TB] FAIL reset_async: got %h expected %h", obs, 15'd0);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 15'd0) $display("[TB] FAIL reset_held: got %h expected %h", obs, 15'd0);
        else n_pass++;
        rstn = 1'b1;
        model_reset();
        drive_cycle(0, 5, 1, 1, 0);
        n_checks++;
        if (obs !== exp_vec()) $display("[TB] FAIL idle_ignores_step_ack: got %h expected %h", obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_full_traversal();
        int pulses = 0;
        drive_cycle(1, 3, 0, 0, 0);
        n_checks++;
        if (obs !== exp_vec()) $display("[TB] FAIL full_start: got %h expected %h", obs, exp_vec());
        else n_pass++;
        for (int i = 1; i <= 16; i++) begin
            drive_cycle(0, 3, 1, 0, 0);
            if (row_end_o === 1'b1) pulses++;
            n_checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL full_step%0d: got %h expected %h", i, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (pulses != 4) $display("[TB] FAIL full_row_end_count: got %0d expected 4", pulses);
        else n_pass++;
        n_checks++;
        if ({done_o, col_o, row_o} !== {1'b1, 6'd3, 6'd3})
            $display("[TB] FAIL full_final: got done=%b col=%0d row=%0d expected done=1 col=3 row=3", done_o, col_o, row_o);
        else n_pass++;
        drive_cycle(0, 3, 1, 0, 0);
        n_checks++;
        if (obs !== exp_vec()) $display("[TB] FAIL full_done_hold: got %h expected %h", obs, exp_vec());
        else n_pass++;
        drive_cycle(0, 3, 0, 1, 0);
        n_checks++;
        if (obs !== 15'd0) $display("[TB] FAIL full_ack: got %h expected %h", obs, 15'd0);
        else n_pass++;
    endtask

    task automatic test_size_zero();
        drive_cycle(1, 0, 0, 0, 0);
        drive_cycle(0, 0, 1, 0, 0);
        n_checks++;
        if ({done_o, row_end_o, busy_o} !== 3'b110)
            $display("[TB] FAIL zero_one_step: got done=%b row_end=%b busy=%b expected 1 1 0", done_o, row_end_o, busy_o);
        else n_pass++;
        drive_cycle(0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== exp_vec()) $display("[TB] FAIL zero_pulse_once: got %h expected %h", obs, exp_vec());
        else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_offset_wrap();
        start_b = 1'b1; size_b = 6'd63;
        @(posedge clk); #1;
        start_b = 1'b0; size_b = 6'd0;
        n_checks++;
        if ({busy_b, done_b, col_b, row_b} !== {1'b1, 1'b0, 6'd0, 6'd0})
            $display("[TB] FAIL wrap_start: got busy=%b done=%b col=%0d row=%0d expected 1 0 0 0", busy_b, done_b, col_b, row_b);
        else n_pass++;
        step_b = 1'b1;
        @(posedge clk); #1;
        step_b = 1'b0;
        n_checks++;
        if ({done_b, row_end_b, busy_b, col_b, row_b} !== {1'b1, 1'b1, 1'b0, 6'd0, 6'd0})
            $display("[TB] FAIL wrap_single_step: got done=%b row_end=%b busy=%b col=%0d row=%0d expected 1 1 0 0 0",
                     done_b, row_end_b, busy_b, col_b, row_b);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({done_b, row_end_b} !== 2'b10) $display("[TB] FAIL wrap_done_hold: got %b expected 10", {done_b, row_end_b});
        else n_pass++;
        ack_b = 1'b1;
        @(posedge clk); #1;
        ack_b = 1'b0;
    endtask

    task automatic test_step_toggle();
        int steps = 0;
        drive_cycle(1, 2, 0, 0, 0);
        for (int cyc = 0; cyc < 40 && done_o !== 1'b1; cyc++) begin
            bit st;
            st = (cyc % 2 == 0);
            drive_cycle(0, int'($urandom_range(0, 63)), st, 0, 0);
            if (st) steps++;
            n_checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL toggle_cyc%0d: got %h expected %h", cyc, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (done_o !== 1'b1 || steps != 9) $display("[TB] FAIL toggle_steps: got done=%b steps=%0d expected done=1 steps=9", done_o, steps);
        else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid_run();
        int steps = 0;
        drive_cycle(1, 3, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive_cycle(0, 3, 1, 0, 0);
        n_checks++;
        if ({col_o, row_o} !== {6'd2, 6'd1}) $display("[TB] FAIL midrun_pos: got col=%0d row=%0d expected col=2 row=1", col_o, row_o);
        else n_pass++;
        #3 rstn = 1'b0;
        #1;
        n_checks++;
        if (obs !== 15'd0) $display("[TB] FAIL midrun_async_clear: got %h expected %h", obs, 15'd0);
        else n_pass++;
        model_reset();
        @(posedge clk); #3;
        rstn = 1'b1;
        @(posedge clk); #1;
        drive_cycle(1, 1, 0, 0, 0);
        for (int cyc = 0; cyc < 20 && done_o !== 1'b1; cyc++) begin
            drive_cycle(0, 1, 1, 0, 0);
            steps++;
            n_checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL postreset_step%0d: got %h expected %h", steps, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (done_o !== 1'b1 || steps != 4) $display("[TB] FAIL postreset_steps: got done=%b steps=%0d expected done=1 steps=4", done_o, steps);
        else n_pass++;
    endtask

    task automatic test_start_ack_together();
        drive_cycle(1, 5, 0, 1, 0);
        n_checks++;
        if (obs !== exp_vec() || busy_o !== 1'b0)
            $display("[TB] FAIL start_ack_done: got %h expected %h", obs, exp_vec());
        else n_pass++;
        drive_cycle(0, 5, 1, 0, 0);
        n_checks++;
        if (busy_o !== 1'b0 || obs !== exp_vec()) $display("[TB] FAIL start_ack_stays_idle: got %h expected %h", obs, exp_vec());
        else n_pass++;
    endtask

`ifdef AUX_CNT_CMP_ABORT_EN
    task automatic test_abort();
        int seen_done = 0;
        drive_cycle(1, 3, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 3, 1, 0, 0);
            if (done_o === 1'b1) seen_done++;
        end
        drive_cycle(0, 3, 1, 1, 1);
        n_checks++;
        if (obs !== 15'd0 || seen_done != 0) $display("[TB] FAIL abort_run: got %h done_seen=%0d expected 0", obs, seen_done);
        else n_pass++;
        drive_cycle(1, 0, 0, 0, 0);
        drive_cycle(0, 0, 1, 0, 0);
        drive_cycle(0, 0, 0, 1, 1);
        n_checks++;
        if (obs !== exp_vec()) $display("[TB] FAIL abort_done: got %h expected %h", obs, exp_vec());
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit s, st, a, ab;
            int sz;
            s  = ($urandom_range(0, 3) == 0);
            sz = int'($urandom_range(0, 4));
            st = $urandom_range(0, 1);
            a  = ($urandom_range(0, 2) == 0);
            ab = 1'b0;
`ifdef AUX_CNT_CMP_ABORT_EN
            ab = ($urandom_range(0, 15) == 0);
`endif
            drive_cycle(s, sz, st, a, ab);
            n_checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL random_cyc%0d: got %h expected %h", cyc, obs, exp_vec());
            else n_pass++;
        end
    endtask

    // Main sequence: every scenario runs to completion, then one summary.
    initial begin
        rstn    = 1'b0;
        start_i = 1'b0; size_i = '0; step_i = 1'b0; ack_i = 1'b0;
        start_b = 1'b0; size_b = '0; step_b = 1'b0; ack_b = 1'b0;
`ifdef AUX_CNT_CMP_ABORT_EN
        abort_i = 1'b0;
        abort_b = 1'b0;
`endif
        test_reset();
        test_full_traversal();
        test_size_zero();
        test_offset_wrap();
        test_step_toggle();
        test_reset_mid_run();
        test_start_ack_together();
`ifdef AUX_CNT_CMP_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Backstop so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
